// File: rtl/alu_nibble_seq.sv
// Nibble-serial ALU controller: streams a WIDTH-bit operation through an external
// 4-bit CLA slice, LSB nibble first. Optional RESP->RUN bypass: ALU_NIBBLE_SEQ_BYPASS_EN.
module alu_nibble_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic [3:0]       slice_less,
  output logic [2:0]       slice_aluop,
  output logic             slice_c0,
  input  logic [3:0]       slice_r,
  input  logic             slice_c4
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  // Handshakes: a transfer happens on any rising edge where valid and ready are
  // both high; valid never drops and payload never changes until that edge.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [KW-1:0]    k_q, k_d;
  logic             cy_q, cy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  logic             take;
  logic             is_arith;
  logic [WIDTH-1:0] res_step;
  logic [WIDTH-1:0] fin_result;
  logic             a_msb, b_msb, r_msb, add_ovf, sub_ovf;

  always_comb begin
    req_ready = 1'b0;
    if (rst_n) begin
      if (state_q == S_IDLE) begin
        req_ready = 1'b1;
      end
`ifdef ALU_NIBBLE_SEQ_BYPASS_EN
      else if (state_q == S_RESP) begin
        req_ready = rsp_ready;
      end
`endif
    end
  end

  assign take     = req_valid & req_ready;
  assign is_arith = op_q[2];

  // Slice pins are only live during RUN; logic ops never see a carry-in.
  always_comb begin
    slice_a     = 4'd0;
    slice_b     = 4'd0;
    slice_less  = 4'd0;
    slice_aluop = 3'd0;
    slice_c0    = 1'b0;
    if (state_q == S_RUN) begin
      slice_a     = a_q[4*k_q +: 4];
      slice_b     = b_q[4*k_q +: 4];
      slice_aluop = (op_q == OP_SLT) ? OP_SUB : op_q;
      slice_c0    = is_arith ? cy_q : 1'b0;
    end
  end

  always_comb begin
    res_step = res_q;
    res_step[4*k_q +: 4] = slice_r;
  end

  assign a_msb   = a_q[WIDTH-1];
  assign b_msb   = b_q[WIDTH-1];
  assign r_msb   = slice_r[3];
  assign add_ovf = (a_msb == b_msb) & (r_msb != a_msb);
  assign sub_ovf = (a_msb != b_msb) & (r_msb != a_msb);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    k_d          = k_q;
    cy_d         = cy_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    fin_result   = res_step;

    case (state_q)
      S_RUN: begin
        res_d = res_step;
        cy_d  = slice_c4;
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_carry_d = 1'b0;
          rsp_ovf_d   = 1'b0;
          case (op_q)
            OP_ADD: begin
              rsp_carry_d = slice_c4;
              rsp_ovf_d   = add_ovf;
            end
            OP_SUB: begin
              rsp_carry_d = slice_c4;
              rsp_ovf_d   = sub_ovf;
            end
            OP_SLT: fin_result = {{(WIDTH-1){1'b0}}, r_msb ^ sub_ovf};
            default: ;
          endcase
          rsp_result_d = fin_result;
          rsp_zero_d   = (fin_result == '0);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // Accept applies from IDLE, and from RESP when the bypass lets req_ready follow rsp_ready.
    if (take) begin
      op_d  = req_op;
      a_d   = req_a;
      b_d   = req_b;
      res_d = '0;
      k_d   = '0;
      cy_d  = (req_op == OP_SUB) || (req_op == OP_SLT);
      if (req_op == OP_ILL) begin
        state_d      = S_RESP;
        rsp_valid_d  = 1'b1;
        rsp_err_d    = 1'b1;
        rsp_result_d = '0;
        rsp_carry_d  = 1'b0;
        rsp_ovf_d    = 1'b0;
        rsp_zero_d   = 1'b1;
      end else begin
        state_d     = S_RUN;
        rsp_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= 3'd0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      k_q          <= '0;
      cy_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      k_q          <= k_d;
      cy_q         <= cy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq (WIDTH=32) with a behavioural 4-bit slice model.
module tb_alu_nibble_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_ovf;
  logic        rsp_zero;
  logic        rsp_err;
  logic [3:0]  slice_a;
  logic [3:0]  slice_b;
  logic [3:0]  slice_less;
  logic [2:0]  slice_aluop;
  logic        slice_c0;
  logic [3:0]  slice_r;
  logic        slice_c4;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  alu_nibble_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .slice_a(slice_a), .slice_b(slice_b), .slice_less(slice_less),
    .slice_aluop(slice_aluop), .slice_c0(slice_c0),
    .slice_r(slice_r), .slice_c4(slice_c4)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External 4-bit slice: inverts B for 100/110/111, adds for 100/101.
  logic [3:0] sl_bb;
  logic [4:0] sl_sum;
  always_comb begin
    sl_bb    = (slice_aluop[2] && slice_aluop != 3'b101) ? ~slice_b : slice_b;
    sl_sum   = {1'b0, slice_a} + {1'b0, sl_bb} + {4'd0, slice_c0};
    slice_r  = 4'd0;
    slice_c4 = 1'b0;
    case (slice_aluop)
      3'b000: slice_r = slice_a & slice_b;
      3'b001: slice_r = slice_a | slice_b;
      3'b010: slice_r = slice_a ^ slice_b;
      3'b011: slice_r = ~(slice_a | slice_b);
      default: begin
        slice_r  = sl_sum[3:0];
        slice_c4 = sl_sum[4];
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Driver: present a request at a negedge, check it is accepted on the next edge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_res);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    exp_q.push_back(exp_res);
    #1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called at the first negedge after the accept edge; that edge counts as 1.
  task automatic wait_rsp(input logic [2:0] op, input int exp_lat);
    int lat;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      if (op == 3'b110) chk("slt_aluop", {29'd0, slice_aluop}, 32'd4);
      if (!op[2])       chk("logic_c0", {31'd0, slice_c0}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    if (op == 3'b111) chk("ill_aluop", {29'd0, slice_aluop}, 32'd0);
  endtask

  // Scoreboard: compare the response against the queued expected result and flags.
  task automatic check_rsp(input string tag, input logic c, input logic o,
                           input logic z, input logic e);
    logic [31:0] exp_res;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp_res = exp_q.pop_front();
      chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_result"}, rsp_result, exp_res);
      chk({tag, "_flags"}, {28'd0, rsp_carry, rsp_ovf, rsp_zero, rsp_err},
          {28'd0, c, o, z, e});
    end
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("drain_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    send(3'b101, 32'h0000FFFF, 32'h00000001, 32'h00010000);
    wait_rsp(3'b101, 9);
    check_rsp("add_ffff", 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    send(3'b100, 32'h80000000, 32'h00000001, 32'h7FFFFFFF);
    wait_rsp(3'b100, 9);
    check_rsp("sub_ovf", 1'b1, 1'b1, 1'b0, 1'b0);
    drain();

    send(3'b100, 32'd5, 32'd5, 32'd0);
    wait_rsp(3'b100, 9);
    check_rsp("sub_zero", 1'b1, 1'b0, 1'b1, 1'b0);
    drain();

    send(3'b110, 32'hFFFFFFFF, 32'h00000001, 32'd1);
    wait_rsp(3'b110, 9);
    check_rsp("slt_neg", 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    send(3'b110, 32'h7FFFFFFF, 32'h80000000, 32'd0);
    wait_rsp(3'b110, 9);
    check_rsp("slt_ovf", 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    send(3'b111, 32'h12345678, 32'h0, 32'd0);
    wait_rsp(3'b111, 1);
    check_rsp("illegal", 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    send(3'b011, 32'hF0F0F0F0, 32'h0F000F00, 32'h000F000F);
    wait_rsp(3'b011, 9);
    check_rsp("nor", 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Back-pressure: response held while the next request waits.
    send(3'b101, 32'd3, 32'd4, 32'd7);
    wait_rsp(3'b101, 9);
    check_rsp("add_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b1;
    req_op    = 3'b001;
    req_a     = 32'h000000F0;
    req_b     = 32'h0000000F;
    exp_q.push_back(32'h000000FF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_result", rsp_result, 32'd7);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("hs_valid_low", {31'd0, rsp_valid}, 32'd0);
`ifdef ALU_NIBBLE_SEQ_BYPASS_EN
    req_valid = 1'b0;
    chk("bypass_run", {29'd0, slice_aluop}, 32'd1);
`else
    chk("bubble_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
`endif
    wait_rsp(3'b001, 9);
    check_rsp("or_queued", 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    send(3'b010, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555);
    wait_rsp(3'b010, 9);
    check_rsp("xor", 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Reset during the third RUN cycle of an ADD drops it.
    req_valid = 1'b1;
    req_op    = 3'b101;
    req_a     = 32'h11111111;
    req_b     = 32'h22222222;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_result", rsp_result, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_slice", {24'd0, slice_a, 1'b0, slice_aluop}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ready_hi", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    send(3'b000, 32'hDEADBEEF, 32'h0F0F0F0F, 32'h0E0D0E0F);
    wait_rsp(3'b000, 9);
    check_rsp("and_after_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
